// File: rtl/axi_mem_pkg.sv
// Shared constants, state encodings and helpers for the AXI burst SRAM.
// Imported by the address generator and the top-level memory.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LAT,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  // Wrap boundary is (len+1) beats of (1<<size) bytes; returns boundary-1.
  function automatic logic [11:0] wrap_mask(
    input logic [7:0] len,
    input logic [2:0] size
  );
    logic [11:0] beats;
    beats = {4'b0, len} + 12'd1;
    return (beats << size) - 12'd1;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-channel AXI burst address sequencer.
// Latches burst params on load, steps one beat per advance.
module axi_burst_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        count,
  output logic              last,
  output logic              burst_err
);

  localparam int LB = $clog2(DATA_W / 8);

  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] next;
  logic              wrap_len_ok;

  always_comb begin
    step = ADDR_W'(1) << size_q;
    mask = ADDR_W'(wrap_mask(len_q, size_q));
    incr = addr + step;
    next = incr;
    unique case (burst_q)
      BURST_FIXED: next = addr;
      BURST_WRAP:  next = (addr & ~mask) | (incr & mask);
      default:     next = incr;
    endcase
  end

  assign wrap_len_ok = (len_q == 8'd1) || (len_q == 8'd3) ||
                       (len_q == 8'd7) || (len_q == 8'd15);

  assign burst_err = (size_q > 3'(LB)) ||
                     (burst_q == 2'b11) ||
                     ((burst_q == BURST_WRAP) && !wrap_len_ok);

  assign last = (count == len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr    <= '0;
      count   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_INCR;
    end else if (load) begin
      addr    <= start_addr;
      count   <= '0;
      len_q   <= len;
      size_q  <= size;
      burst_q <= burst;
    end else if (advance) begin
      addr  <= next;
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/axi_burst_sram.sv
// AXI4 slave SRAM model with independent read/write burst channels,
// configurable read latency and per-beat SLVERR decode.
module axi_burst_sram
  import axi_mem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                MEM_BYTES = 65536,
  parameter int                RD_LAT    = 1,
  parameter string             INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready
);

  localparam int SB    = DATA_W / 8;
  localparam int LB    = $clog2(SB);
  localparam int WORDS = MEM_BYTES / SB;
  localparam int IW    = $clog2(WORDS);
  localparam int LW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [DATA_W-1:0] mem [WORDS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < ADDR_W'(MEM_BYTES));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IW'((a - BASE_ADDR) >> LB);
  endfunction

  rd_state_t         rs, rs_nxt;
  logic              ar_hs, r_hs, r_present;
  logic [LW-1:0]     lat_cnt;
  logic [ADDR_W-1:0] ra_addr;
  logic [7:0]        ra_count;
  logic              ra_last, ra_err, rd_beat_err;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;

  wr_state_t         ws, ws_nxt;
  logic              aw_hs, w_hs;
  logic [ADDR_W-1:0] wa_addr;
  logic [7:0]        wa_count;
  logic              wa_last, wa_err, w_beat_err, w_mismatch;
  logic              err_acc;
  logic [1:0]        bresp_q;

  logic unused_counts;
  assign unused_counts = ^{ra_count, wa_count};

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (ar_hs),
    .advance    (r_present),
    .start_addr (axi_araddr),
    .len        (axi_arlen),
    .size       (axi_arsize),
    .burst      (axi_arburst),
    .addr       (ra_addr),
    .count      (ra_count),
    .last       (ra_last),
    .burst_err  (ra_err)
  );

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (aw_hs),
    .advance    (w_hs),
    .start_addr (axi_awaddr),
    .len        (axi_awlen),
    .size       (axi_awsize),
    .burst      (axi_awburst),
    .addr       (wa_addr),
    .count      (wa_count),
    .last       (wa_last),
    .burst_err  (wa_err)
  );

  assign ar_hs       = axi_arvalid && axi_arready;
  assign r_hs        = axi_rvalid && axi_rready;
  assign rd_beat_err = ra_err || !in_range(ra_addr);
  // The generator always points at the beat being loaded into the output regs.
  assign r_present   = ((rs == R_LAT) && (lat_cnt == '0)) ||
                       ((rs == R_DATA) && r_hs && !rlast_q);

  always_ff @(posedge clk) begin
    if (reset) rs <= R_IDLE;
    else       rs <= rs_nxt;
  end

  always_comb begin
    rs_nxt = rs;
    case (rs)
      R_IDLE: if (ar_hs) rs_nxt = R_LAT;
      R_LAT:  if (lat_cnt == '0) rs_nxt = R_DATA;
      R_DATA: if (r_hs && rlast_q) rs_nxt = R_IDLE;
      default: rs_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    axi_arready = (rs == R_IDLE) && !reset;
    axi_rvalid  = (rs == R_DATA);
    axi_rlast   = rlast_q && (rs == R_DATA);
    axi_rdata   = rdata_q;
    axi_rresp   = rresp_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
    end else begin
      if (ar_hs)
        lat_cnt <= LW'(RD_LAT - 1);
      else if ((rs == R_LAT) && (lat_cnt != '0))
        lat_cnt <= lat_cnt - LW'(1);
      if (r_present) begin
        rdata_q <= rd_beat_err ? '0 : mem[word_idx(ra_addr)];
        rresp_q <= rd_beat_err ? RESP_SLVERR : RESP_OKAY;
        rlast_q <= ra_last;
      end
    end
  end

  assign aw_hs      = axi_awvalid && axi_awready;
  assign w_hs       = axi_wvalid && axi_wready;
  assign w_beat_err = wa_err || !in_range(wa_addr);
  assign w_mismatch = (axi_wlast != wa_last);

  always_ff @(posedge clk) begin
    if (reset) ws <= W_IDLE;
    else       ws <= ws_nxt;
  end

  always_comb begin
    ws_nxt = ws;
    case (ws)
      W_IDLE: if (aw_hs) ws_nxt = W_DATA;
      W_DATA: if (w_hs && wa_last) ws_nxt = W_RESP;
      W_RESP: if (axi_bready) ws_nxt = W_IDLE;
      default: ws_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    axi_awready = (ws == W_IDLE) && !reset;
    axi_wready  = (ws == W_DATA) && !reset;
    axi_bvalid  = (ws == W_RESP);
    axi_bresp   = bresp_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_acc <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (aw_hs)
        err_acc <= 1'b0;
      else if (w_hs)
        err_acc <= err_acc || w_beat_err || w_mismatch;
      if (w_hs && wa_last)
        bresp_q <= (err_acc || w_beat_err || w_mismatch) ?
                   RESP_SLVERR : RESP_OKAY;
    end
  end

  // Contents survive reset; a read of the same word this cycle sees old data.
  always_ff @(posedge clk) begin
    if (w_hs && !w_beat_err) begin
      for (int b = 0; b < SB; b++) begin
        if (axi_wstrb[b])
          mem[word_idx(wa_addr)][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

endmodule
